// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: slot pool for obstacles, moved on ticks and swept to the renderer after each tick
module obstacle_scheduler #(
  parameter int SLOTS = 4,
  parameter logic [9:0] X_START = 10'd630,
  parameter logic [9:0] STEP = 10'd10,
  parameter logic [9:0] Y_MAX = 10'd440,
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spawn_req,
  input  logic [9:0]       spawn_y,
  input  logic             move_tick,
  input  logic             draw_ready,
  output logic             draw_valid,
  output logic [SW-1:0]    draw_slot,
  output logic [9:0]       draw_x,
  output logic [9:0]       draw_y,
  output logic             frame_done,
  output logic             missed_tick,
  output logic             busy,
  output logic             full,
  output logic [SLOTS-1:0] active_mask,
  output logic [7:0]       drop_count
);
  typedef enum logic {IDLE, DRAW} state_t;
  state_t state;
  logic [SLOTS-1:0] active, pend, survive;
  logic [9:0] x [SLOTS];
  logic [9:0] y [SLOTS];
  logic [SW-1:0] free_idx, cur;
  logic free_any;
  // Lowest free slot, lowest pending slot, and which live slots survive the next move
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    cur = '0;
    survive = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_any = 1'b1;
        free_idx = SW'(i);
      end
      if (pend[i]) cur = SW'(i);
      survive[i] = active[i] && (x[i] >= STEP);
    end
  end
  // Slot pool, sweep sequencing and drop counter; a spawn only ever targets a slot that was free before the edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      active <= '0;
      pend <= '0;
      drop_count <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        x[i] <= '0;
        y[i] <= '0;
      end
    end else begin
      if (state == IDLE) begin
        if (move_tick && enable) begin
          for (int i = 0; i < SLOTS; i++)
            if (survive[i]) x[i] <= x[i] - STEP;
          active <= survive;
          pend <= survive;
          state <= DRAW;
        end
      end else if (pend == '0) state <= IDLE;
      else if (draw_ready) pend <= pend & (pend - SLOTS'(1));
      if (spawn_req && enable) begin
        if (free_any) begin
          active[free_idx] <= 1'b1;
          x[free_idx] <= X_START;
          y[free_idx] <= (spawn_y > Y_MAX) ? Y_MAX : spawn_y;
        end else if (drop_count != 8'hff) drop_count <= drop_count + 8'd1;
      end
    end
  end
  assign busy = (state == DRAW);
  assign draw_valid = busy && (pend != '0);
  assign draw_slot = cur;
  assign draw_x = draw_valid ? x[cur] : '0;
  assign draw_y = draw_valid ? y[cur] : '0;
  assign frame_done = busy && (pend == '0);
  assign missed_tick = busy && move_tick;
  assign full = &active;
  assign active_mask = active;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: randomized and directed checks against a queue-based reference model
module tb_obstacle_scheduler;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, spawn_req = 1'b0, move_tick = 1'b0, draw_ready = 1'b0;
  logic [9:0] spawn_y = '0;
  logic draw_valid, frame_done, missed_tick, busy, full;
  logic [1:0] draw_slot;
  logic [9:0] draw_x, draw_y;
  logic [3:0] active_mask;
  logic [7:0] drop_count;
  int n_chk = 0, n_fail = 0;
  bit m_act [4];
  int m_x [4];
  int m_y [4];
  int q [$];
  bit m_sweep;
  int m_drop;

  obstacle_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .spawn_req(spawn_req), .spawn_y(spawn_y),
    .move_tick(move_tick), .draw_ready(draw_ready), .draw_valid(draw_valid), .draw_slot(draw_slot),
    .draw_x(draw_x), .draw_y(draw_y), .frame_done(frame_done), .missed_tick(missed_tick),
    .busy(busy), .full(full), .active_mask(active_mask), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_mask();
    int m = 0;
    for (int i = 0; i < 4; i++) if (m_act[i]) m |= (1 << i);
    return m;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 0;
      m_x[i] = 0;
      m_y[i] = 0;
    end
    q = {};
    m_sweep = 0;
    m_drop = 0;
  endtask

  task automatic check_all(input bit mt);
    bit v;
    v = m_sweep && q.size() > 0;
    chk("busy", busy, m_sweep);
    chk("draw_valid", draw_valid, v);
    chk("draw_slot", draw_slot, v ? q[0] : 0);
    chk("draw_x", draw_x, v ? m_x[q[0]] : 0);
    chk("draw_y", draw_y, v ? m_y[q[0]] : 0);
    chk("frame_done", frame_done, m_sweep && q.size() == 0);
    chk("missed_tick", missed_tick, m_sweep && mt);
    chk("full", full, m_mask() == 15);
    chk("active_mask", active_mask, m_mask());
    chk("drop_count", drop_count, m_drop);
  endtask

  task automatic cyc(input bit sr, input logic [9:0] sy, input bit mt, input bit rdy, input bit en);
    int f;
    @(negedge clk);
    spawn_req = sr;
    spawn_y = sy;
    move_tick = mt;
    draw_ready = rdy;
    enable = en;
    #1;
    check_all(mt);
    @(posedge clk);
    f = -1;
    for (int i = 3; i >= 0; i--) if (!m_act[i]) f = i;
    if (!m_sweep && mt && en) begin
      for (int i = 0; i < 4; i++)
        if (m_act[i]) begin
          if (m_x[i] < 10) m_act[i] = 0;
          else m_x[i] -= 10;
        end
      q = {};
      for (int i = 0; i < 4; i++) if (m_act[i]) q.push_back(i);
      m_sweep = 1;
    end else if (m_sweep) begin
      if (q.size() == 0) m_sweep = 0;
      else if (rdy) void'(q.pop_front());
    end
    if (sr && en) begin
      if (f >= 0) begin
        m_act[f] = 1;
        m_x[f] = 630;
        m_y[f] = (sy > 440) ? 440 : int'(sy);
      end else if (m_drop < 255) m_drop++;
    end
    #1;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    spawn_req = 0;
    move_tick = 0;
    draw_ready = 0;
    #2 reset = 1;
    #1;
    chk("rst_valid", draw_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mask", active_mask, 0);
    chk("rst_drop", drop_count, 0);
    m_reset();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    cyc(0, 0, 0, 0, 1);
    cyc(1, 10'd100, 0, 1, 1);
    chk("spawn_mask", active_mask, 1);
    chk("spawn_full", full, 0);
    cyc(0, 0, 1, 1, 1);
    chk("tick_valid", draw_valid, 1);
    chk("tick_x", draw_x, 620);
    chk("tick_y", draw_y, 100);
    cyc(0, 0, 0, 1, 1);
    chk("sweep_done", frame_done, 1);
    cyc(0, 0, 0, 1, 1);
    chk("idle_busy", busy, 0);
    cyc(1, 10'd500, 0, 1, 1);
    cyc(0, 0, 1, 0, 1);
    chk("hold_slot", draw_slot, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 10'd7, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("hold_x", draw_x, 610);
    cyc(0, 0, 0, 1, 1);
    chk("clamp_slot", draw_slot, 1);
    chk("clamp_y", draw_y, 440);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 10'd3, 0, 1, 1);
    cyc(1, 10'd4, 0, 1, 1);
    chk("fill_full", full, 1);
    chk("fill_drop", drop_count, 1);
    for (int k = 0; k < 260; k++) cyc(1, 10'd5, 0, 1, 1);
    chk("drop_sat", drop_count, 255);
    mid_reset();
    cyc(0, 0, 1, 1, 1);
    chk("empty_frame", frame_done, 1);
    chk("empty_valid", draw_valid, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 10'd20, 0, 1, 1);
    cyc(1, 10'd50, 1, 1, 1);
    chk("same_mask", active_mask, 3);
    chk("same_slot", draw_slot, 0);
    cyc(0, 0, 0, 1, 1);
    chk("same_done", frame_done, 1);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    chk("dis_busy", busy, 0);
    for (int k = 0; k < 4000; k++) begin
      if (k % 1300 == 1299) mid_reset();
      cyc($urandom_range(0, 7) == 0, 10'($urandom_range(0, 1023)), $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
